// File: rtl/pooling_layer_max_unit.sv
// Max pooling over KERNEL_SIZE x KERNEL_SIZE windows of IEEE-754 single rows.
// Stage 1 reduces each group horizontally; stage 2 accumulates across rows.
module pooling_layer_max_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int OUTPUT_SIZE = 3,
  parameter int ROWS        = 6
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      cache_valid,
  input  logic [OUTPUT_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] cache_data,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0]         data_out,
  output logic                                      out_valid,
  output logic                                      frame_done
);

  localparam int OUT_ROWS = ROWS / KERNEL_SIZE;
  localparam int PW       = $clog2(KERNEL_SIZE);
  localparam int RW       = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [PW-1:0] PH_PRE   = PW'(KERNEL_SIZE - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);

  typedef enum logic [0:0] {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  // Sign-magnitude ordering; NaNs are ordered by their bit patterns.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] res;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      res = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      res = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]) ? a : b;
    end else begin
      res = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]) ? a : b;
    end
    return res;
  endfunction

  state_t                          state_q, state_d;
  logic [PW-1:0]                   phase_q, phase_d;
  logic [RW-1:0]                   row_q, row_d;
  logic                            h_valid_q, h_valid_d;
  logic                            out_valid_q, out_valid_d;
  logic                            frame_done_q, frame_done_d;
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0]           h_max_q [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]           h_max_d [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]           acc_q   [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]           acc_d   [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]           row_max_s [OUTPUT_SIZE];

  // Horizontal reduction of each incoming group; element 0 sits at the group MSBs.
  always_comb begin
    for (int g = 0; g < OUTPUT_SIZE; g++) begin
      row_max_s[g] = cache_data[(OUTPUT_SIZE-g)*KERNEL_SIZE*DATA_WIDTH-1 -: DATA_WIDTH];
      for (int k = 1; k < KERNEL_SIZE; k++) begin
        row_max_s[g] = fmax(row_max_s[g],
          cache_data[(OUTPUT_SIZE-g)*KERNEL_SIZE*DATA_WIDTH-k*DATA_WIDTH-1 -: DATA_WIDTH]);
      end
    end
  end

  // Next-state logic for both pipeline stages, the row phase FSM and the row counter.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    row_d        = row_q;
    h_valid_d    = 1'b0;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    dout_d       = dout_q;
    h_max_d      = h_max_q;
    acc_d        = acc_q;
    if (clear) begin
      // Resync: in-flight row and any pending emit are dropped, datapath held.
      state_d = ACCUM;
      phase_d = '0;
      row_d   = '0;
    end else begin
      h_valid_d = cache_valid;
      if (cache_valid) begin
        h_max_d = row_max_s;
      end else begin
        h_max_d = h_max_q;
      end
      if (h_valid_q) begin
        case (state_q)
          ACCUM: begin
            for (int g = 0; g < OUTPUT_SIZE; g++) begin
              if (phase_q == '0) begin
                acc_d[g] = h_max_q[g];
              end else begin
                acc_d[g] = fmax(acc_q[g], h_max_q[g]);
              end
            end
            phase_d = phase_q + PW'(1);
            if (phase_q == PH_PRE) begin
              state_d = EMIT;
            end else begin
              state_d = ACCUM;
            end
          end
          EMIT: begin
            for (int g = 0; g < OUTPUT_SIZE; g++) begin
              dout_d[(OUTPUT_SIZE-g)*DATA_WIDTH-1 -: DATA_WIDTH] = fmax(acc_q[g], h_max_q[g]);
            end
            out_valid_d = 1'b1;
            phase_d     = '0;
            state_d     = ACCUM;
            if (row_q == ROW_LAST) begin
              frame_done_d = 1'b1;
              row_d        = '0;
            end else begin
              frame_done_d = 1'b0;
              row_d        = row_q + RW'(1);
            end
          end
          default: begin
            state_d = ACCUM;
            phase_d = '0;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      phase_q      <= '0;
      row_q        <= '0;
      h_valid_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dout_q       <= '0;
      for (int g = 0; g < OUTPUT_SIZE; g++) begin
        h_max_q[g] <= '0;
        acc_q[g]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      h_valid_q    <= h_valid_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      dout_q       <= dout_d;
      h_max_q      <= h_max_d;
      acc_q        <= acc_d;
    end
  end

  assign data_out   = dout_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pooling_layer_max_unit.sv
// Randomized scoreboard bench for pooling_layer_max_unit with a window-level reference model.
module tb_pooling_layer_max_unit;
  localparam int DW = 32, K = 2, OS = 3, ROWS = 6;
  localparam int OUT_ROWS = ROWS / K;
  localparam int NW = OS * K;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, cache_valid = 1'b0;
  logic [NW*DW-1:0] cache_data = '0;
  logic [OS*DW-1:0] data_out;
  logic out_valid, frame_done;

  pooling_layer_max_unit #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUTPUT_SIZE(OS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cache_valid(cache_valid),
    .cache_data(cache_data), .data_out(data_out), .out_valid(out_valid), .frame_done(frame_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [OS*DW-1:0] data; logic fd; int cyc; } exp_t;
  exp_t exp_q[$];
  logic [NW*DW-1:0] rows_q[$];
  int checks = 0, failures = 0, out_cnt = 0, pend_cyc = 0;
  logic pend_v = 1'b0;
  logic [NW*DW-1:0] pend_data = '0;
  logic [OS*DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Total order on float bit patterns: negatives below positives, -0 just below +0.
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = longint'(w & 32'h7FFF_FFFF);
    return w[31] ? (-m - 64'sd1) : m;
  endfunction

  function automatic logic [31:0] word_of(input logic [NW*DW-1:0] row, input int i);
    return row[(NW-i)*DW-1 -: DW];
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000;
      3: return 32'hBF80_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [NW*DW-1:0] rand_row();
    logic [NW*DW-1:0] r;
    for (int i = 0; i < NW; i++) r[(NW-i)*DW-1 -: DW] = rand_word();
    return r;
  endfunction

  // Reference: once K rows are collected, each output is the max over its K*K values.
  task automatic feed(input logic [NW*DW-1:0] row, input int c);
    exp_t e;
    logic [31:0] best, v;
    rows_q.push_back(row);
    if (rows_q.size() == K) begin
      e.data = '0;
      for (int g = 0; g < OS; g++) begin
        best = word_of(rows_q[0], g*K);
        for (int r = 0; r < K; r++)
          for (int k = 0; k < K; k++) begin
            v = word_of(rows_q[r], g*K + k);
            if (fkey(v) > fkey(best)) best = v;
          end
        e.data[(OS-g)*DW-1 -: DW] = best;
      end
      out_cnt++;
      e.fd = (out_cnt == OUT_ROWS);
      if (e.fd) out_cnt = 0;
      e.cyc = c + 2;
      exp_q.push_back(e);
      rows_q.delete();
    end
  endtask

  // A row is committed to the model one cycle later, so a clear in that cycle can drop it.
  task automatic drive(input logic cv, input logic [NW*DW-1:0] d, input logic clr);
    @(posedge clk); #1;
    cache_valid = cv; cache_data = d; clear = clr;
    if (clr) begin
      pend_v = 1'b0; rows_q.delete(); out_cnt = 0;
    end else begin
      if (pend_v) feed(pend_data, pend_cyc);
      pend_v = cv; pend_data = d; pend_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, rand_row(), 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pend_v = 1'b0; rows_q.delete(); out_cnt = 0; exp_q.delete();
    repeat (n) begin
      @(posedge clk); #1;
      cache_valid = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1));
      cache_data = rand_row();
    end
    @(posedge clk); #1;
    cache_valid = 1'b0; clear = 1'b0; rst_n = 1'b1;
  endtask

  // Monitor: compares every presented output against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_frame_done", 96'(frame_done), 96'(0));
      chk("rst_data_out", 96'(data_out), 96'(0));
      last_data = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 96'(out_valid), 96'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", 96'(cyc), 96'(e.cyc));
        chk("data_out", 96'(data_out), 96'(e.data));
        chk("frame_done", 96'(frame_done), 96'(e.fd));
        last_data = e.data;
      end
    end else begin
      chk("frame_done_without_valid", 96'(frame_done), 96'(0));
      chk("data_out_hold", 96'(data_out), 96'(last_data));
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missed_out_valid", 96'(out_valid), 96'(1));
        e = exp_q.pop_front();
      end
    end
  end

  logic [NW*DW-1:0] row_a, row_b, row_c, row_d;

  initial begin
    row_a = {32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000, 32'h8000_0000};
    row_b = {32'h3F00_0000, 32'h3F00_0000, 32'hC000_0000, 32'hBF80_0000, 32'h8000_0000, 32'h8000_0000};
    row_c = {32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000};
    row_d = {32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000};

    do_reset(4);

    // Basic window, output two cycles after the second row.
    drive(1'b1, row_a, 1'b0);
    drive(1'b1, row_b, 1'b0);
    idle(2);
    @(negedge clk);
    chk("basic_out_valid", 96'(out_valid), 96'(1));
    chk("basic_data", 96'(data_out), 96'h40000000_BF800000_00000000);

    // Sign/magnitude ordering window.
    drive(1'b1, row_c, 1'b0);
    drive(1'b1, row_d, 1'b0);
    idle(2);
    @(negedge clk);
    chk("sign_data", 96'(data_out), 96'h3F000000_BF800000_00000000);

    // Third window of the frame carries frame_done.
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b1, rand_row(), 1'b0);
    idle(2);
    @(negedge clk);
    chk("frame_done_third", 96'(frame_done), 96'(1));

    // Full frame back to back plus a wrapped window.
    repeat (8) drive(1'b1, rand_row(), 1'b0);
    idle(3);

    // Clear one cycle after a row, then a fresh window.
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b0, rand_row(), 1'b1);
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b1, rand_row(), 1'b0);
    idle(3);

    // Clear together with a row.
    drive(1'b1, rand_row(), 1'b1);
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b1, rand_row(), 1'b0);
    idle(3);

    // Random traffic with occasional clears.
    for (int i = 0; i < 120; i++)
      drive(1'($urandom_range(0, 3) != 0), rand_row(), 1'($urandom_range(0, 19) == 0));
    idle(3);

    // Reset mid-frame, then a new frame from row 0.
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b1, rand_row(), 1'b0);
    drive(1'b1, rand_row(), 1'b0);
    do_reset(2);
    for (int i = 0; i < 12; i++) drive(1'b1, rand_row(), 1'b0);
    idle(4);

    chk("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pooling_layer_max_unit.md
# pooling_layer_max_unit

Computes KERNEL_SIZE×KERNEL_SIZE max pooling on IEEE-754 single-precision feature-map rows. Sits directly downstream of the pooling input cache. Each cache update delivers one input row, already grouped into OUTPUT_SIZE windows of KERNEL_SIZE adjacent values. The block reduces each group horizontally, then accumulates the maximum over KERNEL_SIZE consecutive rows, and emits one pooled output row of OUTPUT_SIZE values.

## Interface
Parameters:
- DATA_WIDTH, 32: word width; IEEE-754 single.
- KERNEL_SIZE, 2: pooling window edge. Must be ≥2.
- OUTPUT_SIZE, 3: windows per row, which is also the number of output values per row.
- ROWS, 6: input rows per feature map. Must be a multiple of KERNEL_SIZE.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- clear, input, 1: synchronous frame resync; sets row phase and row count to 0.
- cache_valid, input, 1: one-cycle pulse; cache_data holds a new row this cycle.
- cache_data, input, OUTPUT_SIZE*KERNEL_SIZE*DATA_WIDTH: packing rules:
  - group g occupies bits [(OUTPUT_SIZE-g)*KERNEL_SIZE*DATA_WIDTH-1 -: KERNEL_SIZE*DATA_WIDTH];
  - element 0 of each group is at the MSB end of that group.
- data_out, output, OUTPUT_SIZE*DATA_WIDTH: pooled row; channel 0 at the MSBs.
- out_valid, output, 1: one-cycle pulse; data_out is valid.
- frame_done, output, 1: one-cycle pulse, coincident with the out_valid of the last output row of a frame.

## Operation
- **Float max rule** (combinational, no NaN handling; NaNs are compared as bit patterns):
  - signs differ: the sign=0 operand wins, so +0 beats -0;
  - both sign=0: the larger magnitude bits win;
  - both sign=1: the smaller magnitude bits win;
  - equal bits: that value.
- **Stage 1:** on cache_valid, h_max[g] <= max over the KERNEL_SIZE elements of group g, for every g. h_valid <= cache_valid.
- **Stage 2:** on h_valid, the row phase p (0..KERNEL_SIZE-1) determines the action:
  - p=0: acc[g] <= h_max[g];
  - 0<p<KERNEL_SIZE-1: acc[g] <= max(acc[g], h_max[g]);
  - p=KERNEL_SIZE-1: data_out[g] <= max(acc[g], h_max[g]); out_valid <= 1.
  - p advances modulo KERNEL_SIZE.
- **Output row counter** r runs 0..ROWS/KERNEL_SIZE-1 and increments on each out_valid.
  - When r reaches its last value: frame_done pulses with out_valid, and r wraps to 0.
- **State machine:** states ACCUM (p<KERNEL_SIZE-1) and EMIT (p=KERNEL_SIZE-1).
  - ACCUM → EMIT when h_valid arrives with p=KERNEL_SIZE-2.
  - EMIT → ACCUM on h_valid.
  - No transition without h_valid.
- data_out holds its last value until the next emit.
- There is no backpressure; the consumer must accept every out_valid.

## Timing
- **Reset values:** data_out=0, out_valid=0, frame_done=0. Internally: h_max=0, acc=0, h_valid=0, p=0, r=0, state ACCUM.
- **Latency:** cache_valid at cycle t → h_valid at t+1 → out_valid/data_out at t+2 (for the final row of a window).
- **Throughput:** cache_valid may assert every cycle; back-to-back rows are fully pipelined.
- **clear** has priority over all other activity that cycle:
  - p and r are set to 0;
  - h_valid is forced to 0, dropping any in-flight stage-1 row;
  - out_valid and frame_done are forced to 0;
  - acc and data_out are unchanged.
  - A cache_valid in the same cycle as clear is discarded.
- **rst_n deasserted mid-frame:** all partial windows are discarded. The next cache_valid is treated as row 0 of a new frame.
- out_valid and frame_done are never high for more than one cycle per emit.

## Test plan
- **Reset:** hold rst_n=0 with random inputs → data_out=0, out_valid=0, frame_done=0. First post-reset row is treated as phase 0.
- **Basic 2×2:**
  - Stimulus: row A groups {1.0,2.0},{-1.0,-2.0},{+0,-0}, i.e. {3F800000,40000000},{BF800000,C0000000},{00000000,80000000}. Then row B groups {0.5,0.5},{-2.0,-1.0},{-0,-0}.
  - Required: out_valid 2 cycles after row B's cache_valid, with data_out = {40000000,BF800000,00000000}.
- **Sign/magnitude ordering:** -2.0 vs -1.0 → BF800000. -1.0 vs 0.5 → 3F000000. +0 vs -0 → 00000000.
- **Full frame, ROWS=6:** 6 back-to-back cache_valid pulses → exactly 3 out_valid pulses, 2 cycles apart. frame_done is high only with the third. A 7th row starts a new window, with r wrapped to 0.
- **clear mid-window:** row, then clear in the next cycle, then 2 rows → exactly one out_valid, computed from the 2 post-clear rows only. No pulse from the pre-clear row.
- **Simultaneous clear and cache_valid:** that row is ignored. The next 2 rows produce one output, and frame_done does not assert early.
